// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encodings,
// mult/div hold default, control-bundle type and the canonical action bundles.
package pipeline_stall_controller_pkg;

  // Default number of cycles EX is held for a mult/div (must be >= 2).
  localparam int unsigned MD_CYCLES_DEFAULT = 4;

  // Sequencer state encodings.
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MD_BUSY = 2'd1;
  localparam logic [1:0] ST_MD_DONE = 2'd2;
  localparam logic [1:0] ST_BR_LD2  = 2'd3;

  // Every pipeline-register control produced in one cycle.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic md_done;
    logic busy;
  } pipe_ctrl_t;

  // No action: all enables on, no bubbles, no flush.
  function automatic pipe_ctrl_t ctrl_default();
    pipe_ctrl_t c;
    c               = '0;
    c.pc_write      = 1'b1;
    c.if_id_write   = 1'b1;
    c.id_ex_write   = 1'b1;
    return c;
  endfunction

  // FREEZE: hold PC, IF/ID and ID/EX; bubble into EX/MEM.
  function automatic pipe_ctrl_t ctrl_freeze();
    pipe_ctrl_t c;
    c               = ctrl_default();
    c.pc_write      = 1'b0;
    c.if_id_write   = 1'b0;
    c.id_ex_write   = 1'b0;
    c.ex_mem_bubble = 1'b1;
    return c;
  endfunction

  // STALL: hold PC and IF/ID; ID/EX still loads, but a control-zero bubble.
  function automatic pipe_ctrl_t ctrl_stall();
    pipe_ctrl_t c;
    c               = ctrl_default();
    c.pc_write      = 1'b0;
    c.if_id_write   = 1'b0;
    c.id_ex_bubble  = 1'b1;
    return c;
  endfunction

  // FLUSH: squash the instruction in IF while the PC takes the new target.
  function automatic pipe_ctrl_t ctrl_flush();
    pipe_ctrl_t c;
    c               = ctrl_default();
    c.if_flush      = 1'b1;
    return c;
  endfunction

  // Values forced onto the outputs while reset is held.
  function automatic pipe_ctrl_t ctrl_reset();
    pipe_ctrl_t c;
    c               = '0;
    c.if_flush      = 1'b1;
    c.id_ex_bubble  = 1'b1;
    c.ex_mem_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// sat_counter: W-bit up-counter that stops at all-ones instead of wrapping.
//   clk  - clock
//   rst  - asynchronous active-high reset (clears q)
//   inc  - count this edge
//   q    - current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Increment unless already saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: central stall/flush sequencer for the 5-stage
// pipeline. Turns single-cycle hazard strobes and the mult/div start strobe
// into PC / IF/ID / ID/EX / EX/MEM enables, bubbles and flushes, including
// multi-cycle stalls, and keeps saturating stall/flush performance counters.
//   clk, rst            - clock, asynchronous active-high reset
//   load_use_hazard     - lw in ID/EX feeds the instruction in ID
//   branch_alu_hazard   - branch in ID needs an ALU result in ID/EX
//   branch_load_hazard  - branch in ID needs a lw result in ID/EX
//   branch_taken, jump  - control transfer resolved in ID
//   md_start            - mult/div sitting in ID/EX
//   pc_write, if_id_write, if_flush, id_ex_write, id_ex_bubble,
//   ex_mem_bubble       - pipeline-register controls (combinational)
//   md_done             - mult/div result advancing into EX/MEM
//   busy                - sequencer not in RUN
//   stall_cycles        - saturating count of cycles with pc_write=0
//   flush_count         - saturating count of cycles with if_flush=1
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_hazard,
  input  logic             branch_alu_hazard,
  input  logic             branch_load_hazard,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             md_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             md_done,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned MD_CNT_W = $clog2(MD_CYCLES);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [MD_CNT_W-1:0] cnt;
  logic [MD_CNT_W-1:0] cnt_nxt;
  pipe_ctrl_t          ctrl;

  // State and mult/div hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and zero-latency controls.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ctrl      = ctrl_default();

    unique case (state)
      ST_RUN, ST_MD_DONE: begin
        state_nxt = ST_RUN;
        // In MD_DONE md_start still reflects the departing mult/div.
        if ((state == ST_RUN) && md_start) begin
          ctrl      = ctrl_freeze();
          state_nxt = ST_MD_BUSY;
          cnt_nxt   = MD_CNT_W'(MD_CYCLES - 2);
        end else if (branch_load_hazard) begin
          ctrl      = ctrl_stall();
          state_nxt = ST_BR_LD2;
        end else if (load_use_hazard || branch_alu_hazard) begin
          ctrl      = ctrl_stall();
        end else if (branch_taken || jump) begin
          ctrl      = ctrl_flush();
        end
        ctrl.md_done = (state == ST_MD_DONE);
      end

      ST_MD_BUSY: begin
        ctrl = ctrl_freeze();
        if (cnt == '0) begin
          state_nxt = ST_MD_DONE;
        end else begin
          cnt_nxt = cnt - MD_CNT_W'(1);
        end
      end

      ST_BR_LD2: begin
        // Branch re-evaluates in RUN once the load data can be forwarded.
        ctrl      = ctrl_stall();
        state_nxt = ST_RUN;
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    ctrl.busy = (state != ST_RUN);

    if (rst) begin
      ctrl = ctrl_reset();
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_flush      = ctrl.if_flush;
  assign id_ex_write   = ctrl.id_ex_write;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign md_done       = ctrl.md_done;
  assign busy          = ctrl.busy;

  // Performance counters.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~ctrl.pc_write),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl.if_flush),
    .q   (flush_count)
  );

endmodule
